// File: rtl/gpr_wb_arb.sv
// Write-back arbiter for the single GPR write port: EXU results vs. LSU load responses.
// Optional macro GPR_WB_FWD_EN adds a combinational forwarding port off the write stage.
module gpr_wb_arb #(
  parameter int ISA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_MAX     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exu_valid,
  output logic                      exu_ready,
  input  logic                      exu_w_en,
  input  logic [REG_ADDR_WIDTH-1:0] exu_rd,
  input  logic [ISA_WIDTH-1:0]      exu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [ISA_WIDTH-1:0]      lsu_data,
  output logic                      gpr_w_en,
  output logic [REG_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [ISA_WIDTH-1:0]      gpr_wdata
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_raddr,
  output logic                      fwd_hit,
  output logic [ISA_WIDTH-1:0]      fwd_data
`endif
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             exu_need;
  logic             lsu_need;
  logic             exu_win;
  logic             lsu_win;
  logic             starved;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  assign exu_need = exu_valid & exu_w_en & (exu_rd != '0);
  assign lsu_need = lsu_valid & (lsu_rd != '0);
  assign starved  = (starve_cnt == STARVE_LIM);

  // LSU has priority on a collision unless the EXU has already lost STARVE_MAX times in a row.
  assign exu_win = exu_need & (~lsu_need | starved);
  assign lsu_win = lsu_need & ~exu_win;

  // Requests that need no port are consumed immediately and never stall.
  assign exu_ready = ~rst & exu_valid & (~exu_need | exu_win);
  assign lsu_ready = ~rst & lsu_valid & (~lsu_need | lsu_win);

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!exu_need || exu_win) begin
      starve_cnt_next = '0;
    end else if (lsu_win && !starved) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_w_en  <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_w_en <= exu_win | lsu_win;
      if (exu_win) begin
        gpr_waddr <= exu_rd;
        gpr_wdata <= exu_data;
      end else if (lsu_win) begin
        gpr_waddr <= lsu_rd;
        gpr_wdata <= lsu_data;
      end
    end
  end

`ifdef GPR_WB_FWD_EN
  // Lets decode see a value in the same cycle the register file is being written.
  assign fwd_hit  = gpr_w_en & (gpr_waddr == fwd_raddr) & (fwd_raddr != '0);
  assign fwd_data = fwd_hit ? gpr_wdata : '0;
`endif

endmodule

// File: doc/gpr_wb_arb.md
Name: gpr_wb_arb

Overview:
Write-back arbiter and scheduler for the single GPR write port. Two requesters share the port:
- the EXU result path (ALU/imm/jump link data plus its gpr_w_en);
- the LSU load-response path, which returns load data a variable number of cycles after issue.

The block grants one writer per cycle, registers the winning write for one cycle, and drives the register-file write port. A starvation counter keeps the EXU from being locked out by back-to-back load returns.

Parameters:
ISA_WIDTH, 32, data width of GPR write data
REG_ADDR_WIDTH, 5, GPR index width
STARVE_MAX, 4, consecutive lost cycles after which EXU overrides LSU priority (≥1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
exu_valid  in  1  EXU write-back request
exu_ready  out  1  EXU request consumed this cycle
exu_w_en  in  1  EXU instruction writes GPR (R/I/U/J type)
exu_rd  in  REG_ADDR_WIDTH  EXU destination
exu_data  in  ISA_WIDTH  EXU write data (srd)
lsu_valid  in  1  load response valid
lsu_ready  out  1  load response consumed this cycle
lsu_rd  in  REG_ADDR_WIDTH  load destination
lsu_data  in  ISA_WIDTH  extended load data
gpr_w_en  out  1  register-file write enable
gpr_waddr  out  REG_ADDR_WIDTH  register-file write index
gpr_wdata  out  ISA_WIDTH  register-file write data

Behaviour:
- Single clock domain: clk. rst is asynchronous and active-high. While rst is high, all registers clear, so gpr_w_en=0, gpr_waddr=0, gpr_wdata=0 and starve_cnt=0. exu_ready and lsu_ready are forced to 0 while rst is high.
- Port need:
  - exu_need = exu_valid & exu_w_en & (exu_rd!=0).
  - lsu_need = lsu_valid & (lsu_rd!=0).
- Null requests: a valid request with no need (store, branch, ebreak, or rd=x0) is consumed the same cycle with ready=1 and no port use. Such a request never blocks, and never counts as a loss.
- Arbitration, combinational:
  - Only one needy requester: it wins.
  - Both needy: LSU wins, unless starve_cnt==STARVE_MAX, in which case EXU wins.
  - A winner's ready=1 in the same cycle. The loser's ready=0, and it must hold valid, rd and data stable until accepted.
- Starvation counter:
  - Width is clog2(STARVE_MAX+1).
  - Increments when exu_need and LSU wins.
  - Clears when EXU wins or when exu_need=0.
  - Saturates at STARVE_MAX.
- Write stage, registered, latency 1: on each posedge the winner's rd/data load into gpr_waddr/gpr_wdata and gpr_w_en=1. With no winner, gpr_w_en=0 and gpr_waddr/gpr_wdata hold their previous values. The register file always accepts, so there is no back-pressure from downstream.
- Sustained throughput is one GPR write per cycle.
- Simultaneous EXU and LSU writes to the same rd: the winner is written first and the loser one or more cycles later, so the later write is the final value. Program-order hazards are the scheduler's responsibility upstream.
- Reset mid-operation: an in-flight write-stage entry is discarded, with no write issued, and the counter clears. Requesters must re-present after reset.

Optional Feature:
Macro: GPR_WB_FWD_EN.
- Defined: adds three ports.
  - fwd_raddr  in  REG_ADDR_WIDTH
  - fwd_hit  out  1
  - fwd_data  out  ISA_WIDTH
- Behaviour with the macro: fwd_hit = gpr_w_en & (gpr_waddr==fwd_raddr) & (fwd_raddr!=0), and fwd_data = gpr_wdata when fwd_hit=1, else 0. Both are purely combinational from the write-stage registers, so a decode read in the same cycle as the register-file write sees the new value.
- Undefined: the ports and logic are absent. Arbitration and timing are identical either way.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> outputs go 0 immediately. After release with no valid input, gpr_w_en stays 0 for 10 cycles.
- EXU only: exu_valid=1, w_en=1, rd=5, data=0x12345678 -> exu_ready=1 in the same cycle. Next cycle gpr_w_en=1, waddr=5, wdata=0x12345678.
- Null consume: exu_valid=1, w_en=0 (store) together with lsu_valid=1, rd=7, data=0xFF -> both ready=1 in the same cycle. Next cycle a single write is issued with waddr=7, wdata=0xFF.
- x0 suppression: lsu_valid=1, rd=0, data=0xDEAD -> lsu_ready=1, and gpr_w_en stays 0.
- Starvation: STARVE_MAX=4, EXU rd=3 held valid while LSU presents continuous loads to rd=9 -> LSU wins 4 cycles, EXU wins cycle 5 (write x3 appears at cycle 6), LSU resumes, and starve_cnt returns to 0.
- Forwarding (GPR_WB_FWD_EN): write x10=0xCAFE in progress, fwd_raddr=10 -> fwd_hit=1, fwd_data=0xCAFE. With fwd_raddr=11 -> fwd_hit=0, fwd_data=0.
